uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Frame controller for the UART receiver. Detects the start edge and runs the per-bit edge counter.
//  Drives the majority-vote sampler's enable/edge count, then collects its voted bit into start/data/parity/stop.
//  Checks parity and stop, and presents the received byte with a one-cycle valid strobe.
//  Sits between the synchronised RX line / sampler and the RX output register/interface.
// PARAMETERS
//  DATA_W   8   data bits per frame, LSB first
// PORTS
//  i_clk            in   1      receiver clock (oversampling clock)
//  i_reset          in   1      synchronous, active-high reset
//  i_rx_in          in   1      RX line, already synchronised; idle high
//  i_Prescale       in   6      oversampling ratio; legal values 8, 16, 32
//  i_par_en         in   1      1 = frame carries a parity bit
//  i_par_typ        in   1      0 = even, 1 = odd parity
//  i_sample_bit     in   1      voted bit from sampler; valid at edge_cnt == P-1
//  o_data_samp_en   out  1      sampler enable
//  o_edge_cnt       out  5      edge index within current bit, 0..P-1
//  o_prescale       out  6      frame-latched prescale, fed to sampler
//  o_p_data         out  DATA_W received byte; holds until next valid frame
//  o_data_valid     out  1      1-cycle pulse: frame OK, o_p_data updated
//  o_par_err        out  1      1-cycle pulse: parity mismatch at frame end
//  o_stp_err        out  1      1-cycle pulse: stop bit sampled 0
//  o_strt_glitch    out  1      1-cycle pulse: start bit voted 1, frame aborted
//  o_busy           out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; edge_cnt, bit_cnt, shift reg, o_p_data, all pulses, o_busy, o_data_samp_en = 0; o_prescale = 8.
//  Reset has priority over all events, including mid-frame; a partial frame is discarded with no pulse.
//  States: IDLE, START, DATA, PARITY, STOP. Let P be the latched prescale and "bit end" mean edge_cnt == P-1.
//  IDLE:
//   - i_rx_in == 0 and i_Prescale in {8,16,32}: latch P, go to START with edge_cnt = 0.
//   - i_Prescale illegal: stay in IDLE and ignore the line.
//  Edge counter:
//   - In non-IDLE states, increments each cycle and wraps P-1 -> 0 at every bit end.
//   - Held at 0 in IDLE.
//  o_data_samp_en = 1 in every non-IDLE state (combinational from state); o_edge_cnt = edge_cnt.
//  START, at bit end:
//   - i_sample_bit == 0: go to DATA, bit_cnt = 0.
//   - Otherwise: pulse o_strt_glitch and go to IDLE.
//  DATA, at bit end:
//   - Shift i_sample_bit into the MSB and shift right, so bit 0 arrives first.
//   - bit_cnt increments; after bit DATA_W-1, go to PARITY if i_par_en, else STOP.
//  PARITY, at bit end:
//   - expected = ^shift (even) or ~^shift (odd).
//   - par_bad = (i_sample_bit != expected), held for the frame; then go to STOP.
//  STOP, at bit end:
//   - stp_bad = ~i_sample_bit. Go to IDLE and, in the next cycle:
//   - Neither error: o_p_data <= shift and o_data_valid = 1.
//   - Otherwise: pulse o_par_err and/or o_stp_err; o_p_data unchanged.
//  All pulses are registered, last exactly 1 cycle, and assert in the first IDLE cycle after the frame.
//  IDLE may detect a new start in that same cycle (back-to-back frames; no extra idle bit needed).
//  i_Prescale, i_par_en and i_par_typ are latched at IDLE->START; changes mid-frame take effect next frame.
//  Frame length in cycles from the IDLE detect cycle t0:
//   - STOP bit end at t0 + P*(1 + DATA_W + par_en + 1); pulses at that time + 1.
//  Widths: edge_cnt 5 bits, since P-1 <= 31; bit_cnt 3 bits for DATA_W = 8.
// TESTING
//  Bench models the sampler as i_sample_bit <= 3-sample vote of i_rx_in around mid-bit, registered at edge P-2.
//  1. P=8, par_en=0, send 0xA5, stop=1, IDLE detect at t0 -> o_data_valid=1 only at t0+81; o_p_data=0xA5; no errors.
//  2. P=16, par_en=1, even, send 0x3C with parity 0 -> valid, o_p_data=0x3C.
//     Repeat with parity 1 -> o_par_err pulse, no valid, o_p_data stays 0x3C.
//  3. P=32, send 0x00 with stop bit = 0 -> o_stp_err pulse, no valid; o_busy low the same cycle.
//  4. P=8, line low 2 cycles then high (glitch) -> o_strt_glitch at t0+9, state IDLE, no data/error pulse.
//  5. P=8, two frames 0x11, 0xEE back-to-back, start bit directly after stop -> two valid pulses 80 cycles apart, bytes correct.
//  6. i_reset=1 during DATA bit 4 -> next cycle IDLE, all outputs 0.
//     Change i_Prescale mid-frame -> current frame unaffected.
//     i_Prescale=12 with line low -> stays IDLE.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive frame controller and its surroundings
// (synchronised RX line, majority-vote sampler and the RX output register).
interface uart_rx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              i_rx_in;
  logic [5:0]        i_Prescale;
  logic              i_par_en;
  logic              i_par_typ;
  logic              i_sample_bit;
  logic              o_data_samp_en;
  logic [4:0]        o_edge_cnt;
  logic [5:0]        o_prescale;
  logic [DATA_W-1:0] o_p_data;
  logic              o_data_valid;
  logic              o_par_err;
  logic              o_stp_err;
  logic              o_strt_glitch;
  logic              o_busy;

  modport master (
    output i_rx_in, i_Prescale, i_par_en, i_par_typ, i_sample_bit,
    input  o_data_samp_en, o_edge_cnt, o_prescale, o_p_data,
           o_data_valid, o_par_err, o_stp_err, o_strt_glitch, o_busy
  );

  modport slave (
    input  i_rx_in, i_Prescale, i_par_en, i_par_typ, i_sample_bit,
    output o_data_samp_en, o_edge_cnt, o_prescale, o_p_data,
           o_data_valid, o_par_err, o_stp_err, o_strt_glitch, o_busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, per-bit edge counting,
// frame assembly from the sampler's voted bit and parity/stop checking.
module uart_rx_ctrl #(
  parameter int DATA_W = 8
) (
  input logic           i_clk,
  input logic           i_reset,
  uart_rx_ctrl_if.slave bus
);
  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {Idle, Start, Data, Parity, Stop} state_e;

  state_e            state_q, state_d;
  logic [4:0]        edgeCnt_q, edgeCnt_d;
  logic [BCW-1:0]    bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] pData_q, pData_d;
  logic [5:0]        prescale_q, prescale_d;
  logic              parEn_q, parEn_d;
  logic              parTyp_q, parTyp_d;
  logic              parBad_q, parBad_d;
  logic              dataValid_q, dataValid_d;
  logic              parErr_q, parErr_d;
  logic              stpErr_q, stpErr_d;
  logic              strtGlitch_q, strtGlitch_d;

  logic bitEnd;
  logic prescaleLegal;
  logic expParity;

  // Prescale of 32 wraps to 0 in 5 bits, so P-1 is formed in 6 bits first.
  assign bitEnd        = (edgeCnt_q == 5'(prescale_q - 6'd1));
  assign prescaleLegal = (bus.i_Prescale == 6'd8) || (bus.i_Prescale == 6'd16) ||
                         (bus.i_Prescale == 6'd32);
  assign expParity     = parTyp_q ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d      = state_q;
    edgeCnt_d    = (state_q == Idle) ? 5'd0 : (bitEnd ? 5'd0 : edgeCnt_q + 5'd1);
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    pData_d      = pData_q;
    prescale_d   = prescale_q;
    parEn_d      = parEn_q;
    parTyp_d     = parTyp_q;
    parBad_d     = parBad_q;
    dataValid_d  = 1'b0;
    parErr_d     = 1'b0;
    stpErr_d     = 1'b0;
    strtGlitch_d = 1'b0;

    unique case (state_q)
      Idle: begin
        if (!bus.i_rx_in && prescaleLegal) begin
          state_d    = Start;
          prescale_d = bus.i_Prescale;
          parEn_d    = bus.i_par_en;
          parTyp_d   = bus.i_par_typ;
          parBad_d   = 1'b0;
        end
      end
      Start: begin
        if (bitEnd) begin
          if (!bus.i_sample_bit) begin
            state_d  = Data;
            bitCnt_d = '0;
          end else begin
            strtGlitch_d = 1'b1;
            state_d      = Idle;
          end
        end
      end
      Data: begin
        if (bitEnd) begin
          shift_d  = {bus.i_sample_bit, shift_q[DATA_W-1:1]};
          bitCnt_d = bitCnt_q + BCW'(1);
          if (bitCnt_q == BCW'(DATA_W - 1)) begin
            state_d = parEn_q ? Parity : Stop;
          end
        end
      end
      Parity: begin
        if (bitEnd) begin
          parBad_d = (bus.i_sample_bit != expParity);
          state_d  = Stop;
        end
      end
      Stop: begin
        // Result pulses register here so they land in the first Idle cycle.
        if (bitEnd) begin
          state_d  = Idle;
          parErr_d = parBad_q;
          stpErr_d = !bus.i_sample_bit;
          if (!parBad_q && bus.i_sample_bit) begin
            dataValid_d = 1'b1;
            pData_d     = shift_q;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= Idle;
      edgeCnt_q    <= 5'd0;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      pData_q      <= '0;
      prescale_q   <= 6'd8;
      parEn_q      <= 1'b0;
      parTyp_q     <= 1'b0;
      parBad_q     <= 1'b0;
      dataValid_q  <= 1'b0;
      parErr_q     <= 1'b0;
      stpErr_q     <= 1'b0;
      strtGlitch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edgeCnt_q    <= edgeCnt_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      pData_q      <= pData_d;
      prescale_q   <= prescale_d;
      parEn_q      <= parEn_d;
      parTyp_q     <= parTyp_d;
      parBad_q     <= parBad_d;
      dataValid_q  <= dataValid_d;
      parErr_q     <= parErr_d;
      stpErr_q     <= stpErr_d;
      strtGlitch_q <= strtGlitch_d;
    end
  end

  assign bus.o_data_samp_en = (state_q != Idle);
  assign bus.o_busy         = (state_q != Idle);
  assign bus.o_edge_cnt     = edgeCnt_q;
  assign bus.o_prescale     = prescale_q;
  assign bus.o_p_data       = pData_q;
  assign bus.o_data_valid   = dataValid_q;
  assign bus.o_par_err      = parErr_q;
  assign bus.o_stp_err      = stpErr_q;
  assign bus.o_strt_glitch  = strtGlitch_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames, models the sampler, and checks
// every result pulse (cycle, kind, byte) against a frame-level reference model.
module tb_uart_rx_ctrl;
  logic clk;
  logic reset;
  int   cyc = 0;
  int   vecCount = 0;
  int   missCount = 0;

  typedef struct {
    int         cyc;
    logic [3:0] flags;
    logic       busy;
    logic [7:0] data;
  } ev_t;

  ev_t  expQ[$];
  ev_t  obsQ[$];
  ev_t  obsEv;
  int   idleFrom;
  logic [7:0] lastData;
  logic [2:0] votes;

  uart_rx_ctrl_if #(.DATA_W(8)) rxIf();

  uart_rx_ctrl #(.DATA_W(8)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (rxIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sampler stand-in: 3-sample majority around mid-bit, presented from edge P-1.
  always @(posedge clk) begin
    if (reset) begin
      votes               <= 3'b111;
      rxIf.i_sample_bit   <= 1'b1;
    end else if (rxIf.o_data_samp_en) begin
      if (int'(rxIf.o_edge_cnt) == int'(rxIf.o_prescale) / 2 - 1) votes[0] <= rxIf.i_rx_in;
      if (int'(rxIf.o_edge_cnt) == int'(rxIf.o_prescale) / 2)     votes[1] <= rxIf.i_rx_in;
      if (int'(rxIf.o_edge_cnt) == int'(rxIf.o_prescale) / 2 + 1) votes[2] <= rxIf.i_rx_in;
      if (int'(rxIf.o_edge_cnt) == int'(rxIf.o_prescale) - 2)
        rxIf.i_sample_bit <= (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
    end
  end

  always @(negedge clk) begin
    if (rxIf.o_data_valid | rxIf.o_par_err | rxIf.o_stp_err | rxIf.o_strt_glitch) begin
      obsEv.cyc   = cyc;
      obsEv.flags = {rxIf.o_data_valid, rxIf.o_par_err, rxIf.o_stp_err, rxIf.o_strt_glitch};
      obsEv.busy  = rxIf.o_busy;
      obsEv.data  = rxIf.o_p_data;
      obsQ.push_back(obsEv);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic driveLine(input logic v, input int n);
    rxIf.i_rx_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame; the expected result pulse is derived from frame arithmetic:
  // detect at t0, result one cycle after t0 + P * (number of bits on the wire).
  task automatic applyStimulus(input int p, input bit parEn, input bit parTyp,
                               input logic [7:0] data, input bit badPar,
                               input bit badStop, input bit glitch, input bit midChange);
    ev_t  e;
    int   t0;
    logic parBit;
    logic [7:0] d;
    d = data;
    rxIf.i_Prescale = 6'(p);
    rxIf.i_par_en   = parEn;
    rxIf.i_par_typ  = parTyp;
    t0 = (cyc >= idleFrom) ? cyc : idleFrom;
    e.busy = 1'b0;
    if (glitch) begin
      e.cyc   = t0 + p + 1;
      e.flags = 4'b0001;
      e.data  = lastData;
      expQ.push_back(e);
      idleFrom = e.cyc;
      driveLine(1'b0, 2);
      driveLine(1'b1, p - 2);
    end else begin
      parBit  = (parTyp ? ~^d : ^d) ^ badPar;
      e.cyc   = t0 + p * (10 + int'(parEn)) + 1;
      e.flags = {!(parEn && badPar) && !badStop, parEn && badPar, badStop, 1'b0};
      if (e.flags[3]) lastData = d;
      e.data  = lastData;
      expQ.push_back(e);
      idleFrom = e.cyc;
      driveLine(1'b0, p);
      for (int i = 0; i < 8; i++) begin
        driveLine(d[i], p);
        if (midChange && i == 3) begin
          rxIf.i_Prescale = 6'($urandom_range(4, 40));
          rxIf.i_par_en   = 1'($urandom);
          rxIf.i_par_typ  = 1'($urandom);
        end
      end
      if (parEn) driveLine(parBit, p);
      driveLine(!badStop, p);
      rxIf.i_rx_in = 1'b1;
    end
  endtask

  task automatic checkEvents();
    ev_t o;
    ev_t x;
    for (int k = 0; k < 2000 && cyc < idleFrom + 2; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("eventCount", 32'(obsQ.size()), 32'(expQ.size()));
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      x = expQ.pop_front();
      checkOutput("pulseCycle", 32'(o.cyc), 32'(x.cyc));
      checkOutput("pulseKind", 32'(o.flags), 32'(x.flags));
      checkOutput("busyAtPulse", 32'(o.busy), 32'(x.busy));
      checkOutput("pData", 32'(o.data), 32'(x.data));
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(rxIf.o_busy), 32'd0);
    checkOutput({tag, "_sampEn"}, 32'(rxIf.o_data_samp_en), 32'd0);
    checkOutput({tag, "_edgeCnt"}, 32'(rxIf.o_edge_cnt), 32'd0);
    checkOutput({tag, "_prescale"}, 32'(rxIf.o_prescale), 32'd8);
    checkOutput({tag, "_pData"}, 32'(rxIf.o_p_data), 32'd0);
    checkOutput({tag, "_pulses"},
                32'({rxIf.o_data_valid, rxIf.o_par_err, rxIf.o_stp_err, rxIf.o_strt_glitch}), 32'd0);
  endtask

  task automatic resetMidFrame();
    logic [7:0] d;
    d = 8'($urandom);
    rxIf.i_Prescale = 6'd8;
    rxIf.i_par_en   = 1'b0;
    driveLine(1'b0, 8);
    for (int i = 0; i < 4; i++) driveLine(d[i], 8);
    driveLine(d[4], 4);
    checkOutput("busyMidFrame", 32'(rxIf.o_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("midReset");
    reset = 1'b0;
    rxIf.i_rx_in = 1'b1;
    lastData = 8'h00;
    idleFrom = cyc;
  endtask

  task automatic illegalPrescale();
    rxIf.i_Prescale = 6'd12;
    driveLine(1'b0, 1);
    checkOutput("illegalP_busy1", 32'(rxIf.o_busy), 32'd0);
    driveLine(1'b0, 20);
    checkOutput("illegalP_busy2", 32'(rxIf.o_busy), 32'd0);
    checkOutput("illegalP_edge", 32'(rxIf.o_edge_cnt), 32'd0);
    driveLine(1'b1, 2);
    rxIf.i_Prescale = 6'd8;
  endtask

  initial begin
    int p;
    bit parEn;
    reset           = 1'b1;
    rxIf.i_rx_in    = 1'b1;
    rxIf.i_Prescale = 6'd8;
    rxIf.i_par_en   = 1'b0;
    rxIf.i_par_typ  = 1'b0;
    lastData        = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    reset    = 1'b0;
    idleFrom = cyc;
    driveLine(1'b1, 4);

    applyStimulus(8, 0, 0, 8'hA5, 0, 0, 0, 0);
    checkEvents();
    applyStimulus(16, 1, 0, 8'h3C, 0, 0, 0, 0);
    checkEvents();
    applyStimulus(16, 1, 0, 8'h3C, 1, 0, 0, 0);
    checkEvents();
    applyStimulus(32, 0, 0, 8'h00, 0, 1, 0, 0);
    checkEvents();
    applyStimulus(8, 0, 0, 8'hFF, 0, 0, 1, 0);
    checkEvents();
    applyStimulus(8, 0, 0, 8'h11, 0, 0, 0, 0);
    applyStimulus(8, 0, 0, 8'hEE, 0, 0, 0, 0);
    checkEvents();
    applyStimulus(16, 1, 1, 8'h5A, 0, 0, 0, 1);
    checkEvents();
    resetMidFrame();
    checkEvents();
    illegalPrescale();
    checkEvents();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      parEn = 1'($urandom);
      if ($urandom_range(0, 2) != 0) driveLine(1'b1, $urandom_range(1, 6));
      while (cyc < idleFrom - 1) driveLine(1'b1, 1);
      applyStimulus(p, parEn, 1'($urandom), 8'($urandom),
                    parEn && ($urandom_range(0, 3) == 0), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 7) == 0, 1'($urandom));
    end
    checkEvents();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
